// File: rtl/dds_controller_if.sv
// Button and tuning-output bundle between the front panel and the DDS controller.
// The panel/bench side is the master; the controller is the slave.
interface dds_controller_if #(
  parameter int FW_WIDTH = 12
);
  logic                freq_up_n;
  logic                freq_dn_n;
  logic                wave_next_n;
  logic [FW_WIDTH-1:0] freq_word;
  logic [3:0]          wave_sel;
  logic                update;

  modport master (
    output freq_up_n, freq_dn_n, wave_next_n,
    input  freq_word, wave_sel, update
  );

  modport slave (
    input  freq_up_n, freq_dn_n, wave_next_n,
    output freq_word, wave_sel, update
  );
endinterface

// File: rtl/dds_controller.sv
// Front-panel controller for a DDS: debounces three push buttons and steps the
// frequency word / waveform index, pulsing update whenever either changes.
module dds_controller #(
  parameter int FW_WIDTH   = 12,
  parameter int FW_STEP    = 8,
  parameter int FW_MIN     = 8,
  parameter int FW_MAX     = 4000,
  parameter int WRAP       = 0,
  parameter int N_WAVES    = 4,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  dds_controller_if.slave  bus
);

  localparam int EXT_W = FW_WIDTH + 1;
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [FW_WIDTH-1:0] FW_MIN_W  = FW_WIDTH'(FW_MIN);
  localparam logic [FW_WIDTH-1:0] FW_MAX_W  = FW_WIDTH'(FW_MAX);
  localparam logic [EXT_W-1:0]    STEP_X    = EXT_W'(FW_STEP);
  localparam logic [EXT_W-1:0]    MIN_X     = EXT_W'(FW_MIN);
  localparam logic [EXT_W-1:0]    MAX_X     = EXT_W'(FW_MAX);
  localparam logic [3:0]          WAVE_LAST = 4'(N_WAVES - 1);

  // Bit 0 = up, bit 1 = down, bit 2 = wave; all active-low levels.
  logic [2:0]            btn_s;
  logic [2:0]            sync1_r;
  logic [2:0]            sync2_r;
  logic [2:0]            prev_r;
  logic [2:0]            deb_r;
  logic [2:0]            deb_d_r;
  logic [2:0][CNT_W-1:0] cnt_r;
  logic [2:0][CNT_W-1:0] cnt_nxt_s;
  logic [2:0]            deb_load_s;
  logic [2:0]            press_s;

  logic [FW_WIDTH-1:0]   freq_word_r;
  logic [FW_WIDTH-1:0]   freq_nxt_s;
  logic [3:0]            wave_sel_r;
  logic [3:0]            wave_nxt_s;
  logic                  update_r;
  logic [EXT_W-1:0]      ext_s;
  logic [EXT_W-1:0]      up_sum_s;
  logic [EXT_W-1:0]      dn_diff_s;

  assign btn_s = {bus.wave_next_n, bus.freq_dn_n, bus.freq_up_n};

  // Debounce counters restart on any synchronised level change; the level is accepted on reaching CNT_MAX.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_nxt_s[i]  = CNT_ZERO;
      deb_load_s[i] = 1'b0;
      if (sync2_r[i] != prev_r[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] != CNT_MAX) begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
      deb_load_s[i] = (sync2_r[i] == prev_r[i]) && (cnt_nxt_s[i] == CNT_MAX);
    end
  end

  // Synchronisers, debounce state and edge-detect history for all three buttons.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_r <= 3'b111;
      sync2_r <= 3'b111;
      prev_r  <= 3'b111;
      deb_r   <= 3'b111;
      deb_d_r <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      deb_d_r <= deb_r;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
        if (deb_load_s[i]) begin
          deb_r[i] <= sync2_r[i];
        end
      end
    end
  end

  assign press_s   = deb_d_r & ~deb_r;
  assign ext_s     = {1'b0, freq_word_r};
  assign up_sum_s  = ext_s + STEP_X;
  assign dn_diff_s = ext_s - STEP_X;

  // Next frequency word and waveform index; opposing frequency presses cancel.
  always_comb begin
    freq_nxt_s = freq_word_r;
    wave_nxt_s = wave_sel_r;
    if (press_s[0] && !press_s[1]) begin
      if (up_sum_s <= MAX_X) begin
        freq_nxt_s = up_sum_s[FW_WIDTH-1:0];
      end else if (WRAP != 0) begin
        freq_nxt_s = FW_MIN_W;
      end else begin
        freq_nxt_s = FW_MAX_W;
      end
    end else if (press_s[1] && !press_s[0]) begin
      if ((ext_s >= STEP_X) && (dn_diff_s >= MIN_X)) begin
        freq_nxt_s = dn_diff_s[FW_WIDTH-1:0];
      end else if (WRAP != 0) begin
        freq_nxt_s = FW_MAX_W;
      end else begin
        freq_nxt_s = FW_MIN_W;
      end
    end else begin
      freq_nxt_s = freq_word_r;
    end
    if (press_s[2]) begin
      if (wave_sel_r == WAVE_LAST) begin
        wave_nxt_s = 4'd0;
      end else begin
        wave_nxt_s = wave_sel_r + 4'd1;
      end
    end else begin
      wave_nxt_s = wave_sel_r;
    end
  end

  // Registered outputs; update fires only on an actual change of either value.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      freq_word_r <= FW_MIN_W;
      wave_sel_r  <= 4'd0;
      update_r    <= 1'b0;
    end else begin
      freq_word_r <= freq_nxt_s;
      wave_sel_r  <= wave_nxt_s;
      update_r    <= (freq_nxt_s != freq_word_r) || (wave_nxt_s != wave_sel_r);
    end
  end

  assign bus.freq_word = freq_word_r;
  assign bus.wave_sel  = wave_sel_r;
  assign bus.update    = update_r;

endmodule

// File: tb/tb_dds_controller.sv
// Directed bench: a saturating and a wrapping controller driven by the same buttons.
module tb_dds_controller;

  logic sys_clk;
  logic sys_rst_n;
  int   n_chk;
  int   n_pass;
  int   upd_sat;
  int   upd_wrap;

  dds_controller_if #(.FW_WIDTH(12)) bus_sat ();
  dds_controller_if #(.FW_WIDTH(12)) bus_wrap ();

  dds_controller #(
    .FW_WIDTH(12), .FW_STEP(8), .FW_MIN(8), .FW_MAX(32),
    .WRAP(0), .N_WAVES(4), .DEB_CYCLES(4)
  ) u_sat (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus_sat)
  );

  dds_controller #(
    .FW_WIDTH(12), .FW_STEP(8), .FW_MIN(8), .FW_MAX(32),
    .WRAP(1), .N_WAVES(4), .DEB_CYCLES(4)
  ) u_wrap (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus_wrap)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Count update pulses as seen just before each rising edge.
  always @(posedge sys_clk) begin
    if (bus_sat.update === 1'b1)  upd_sat  <= upd_sat + 1;
    if (bus_wrap.update === 1'b1) upd_wrap <= upd_wrap + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk = n_chk + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input logic up, input logic dn, input logic wv);
    bus_sat.freq_up_n    = ~up;
    bus_sat.freq_dn_n    = ~dn;
    bus_sat.wave_next_n  = ~wv;
    bus_wrap.freq_up_n   = ~up;
    bus_wrap.freq_dn_n   = ~dn;
    bus_wrap.wave_next_n = ~wv;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic press_chk(input logic up, input logic dn, input logic wv, input int hold,
                           input string tag, input int f_sat, input int f_wrap,
                           input int w_exp, input int u_sat, input int u_wrap);
    int s0;
    int w0;
    s0 = upd_sat;
    w0 = upd_wrap;
    @(negedge sys_clk);
    set_btn(up, dn, wv);
    repeat (hold) @(negedge sys_clk);
    set_btn(1'b0, 1'b0, 1'b0);
    repeat (12) @(negedge sys_clk);
    chk({tag, "_freq_sat"},  int'(bus_sat.freq_word),  f_sat);
    chk({tag, "_freq_wrap"}, int'(bus_wrap.freq_word), f_wrap);
    chk({tag, "_wave_sat"},  int'(bus_sat.wave_sel),   w_exp);
    chk({tag, "_wave_wrap"}, int'(bus_wrap.wave_sel),  w_exp);
    chk({tag, "_upd_sat"},   upd_sat - s0,             u_sat);
    chk({tag, "_upd_wrap"},  upd_wrap - w0,            u_wrap);
  endtask

  initial begin
    int s0;
    int w0;
    n_chk     = 0;
    n_pass    = 0;
    upd_sat   = 0;
    upd_wrap  = 0;
    sys_rst_n = 1'b0;
    set_btn(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge sys_clk);
    chk("rst_freq_sat",  int'(bus_sat.freq_word),  8);
    chk("rst_freq_wrap", int'(bus_wrap.freq_word), 8);
    chk("rst_wave",      int'(bus_sat.wave_sel),   0);
    chk("rst_upd",       int'(bus_sat.update),     0);
    sys_rst_n = 1'b1;
    repeat (6) @(negedge sys_clk);

    // Long hold gives one step, glitch gives nothing.
    press_chk(1'b1, 1'b0, 1'b0, 20, "hold_up", 16, 16, 0, 1, 1);
    press_chk(1'b1, 1'b0, 1'b0, 2,  "glitch",  16, 16, 0, 0, 0);

    // Climb to the top limit, then saturate or wrap.
    do_reset();
    press_chk(1'b1, 1'b0, 1'b0, 8, "up1", 16, 16, 0, 1, 1);
    press_chk(1'b1, 1'b0, 1'b0, 8, "up2", 24, 24, 0, 1, 1);
    press_chk(1'b1, 1'b0, 1'b0, 8, "up3", 32, 32, 0, 1, 1);
    press_chk(1'b1, 1'b0, 1'b0, 8, "up4", 32, 8,  0, 0, 1);

    // Down at the bottom limit.
    do_reset();
    press_chk(1'b0, 1'b1, 1'b0, 8, "dn_min", 8, 32, 0, 0, 1);

    // Simultaneous up/down cancel; with a wave press a single update.
    press_chk(1'b1, 1'b1, 1'b0, 8, "updn",      8, 32, 0, 0, 0);
    press_chk(1'b1, 1'b1, 1'b1, 8, "updn_wave", 8, 32, 1, 1, 1);

    // Waveform index wraps after N_WAVES-1.
    do_reset();
    press_chk(1'b0, 1'b0, 1'b1, 8, "wave1", 8, 8, 1, 1, 1);
    press_chk(1'b0, 1'b0, 1'b1, 8, "wave2", 8, 8, 2, 1, 1);
    press_chk(1'b0, 1'b0, 1'b1, 8, "wave3", 8, 8, 3, 1, 1);
    press_chk(1'b0, 1'b0, 1'b1, 8, "wave4", 8, 8, 0, 1, 1);
    press_chk(1'b0, 1'b0, 1'b1, 8, "wave5", 8, 8, 1, 1, 1);

    // Reset in the middle of debouncing discards the pending press.
    s0 = upd_sat;
    w0 = upd_wrap;
    @(negedge sys_clk);
    set_btn(1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    set_btn(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    chk("rstmid_freq_sat",  int'(bus_sat.freq_word),  8);
    chk("rstmid_freq_wrap", int'(bus_wrap.freq_word), 8);
    chk("rstmid_wave",      int'(bus_sat.wave_sel),   0);
    chk("rstmid_upd",       upd_sat - s0 + upd_wrap - w0, 0);

    // Button held through reset release: one event after the full debounce.
    set_btn(1'b0, 1'b0, 1'b1);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    s0 = upd_sat;
    sys_rst_n = 1'b1;
    repeat (6) @(negedge sys_clk);
    chk("held_wave_early", int'(bus_sat.wave_sel), 0);
    chk("held_upd_early",  int'(bus_sat.update),   0);
    @(negedge sys_clk);
    chk("held_wave",       int'(bus_sat.wave_sel), 1);
    chk("held_upd_pulse",  int'(bus_sat.update),   1);
    @(negedge sys_clk);
    chk("held_upd_end",    int'(bus_sat.update),   0);
    repeat (10) @(negedge sys_clk);
    set_btn(1'b0, 1'b0, 1'b0);
    repeat (12) @(negedge sys_clk);
    chk("held_wave_final", int'(bus_wrap.wave_sel), 1);
    chk("held_upd_count",  upd_sat - s0,            1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dds_controller.md
DDS_CONTROLLER -- requirements
Module: dds_controller

Interface
REQ-001 Parameter FW_WIDTH, default 12, frequency-word width in bits.
REQ-002 Parameter FW_STEP, default 8, increment/decrement per accepted press.
REQ-003 Parameter FW_MIN, default 8, lowest legal frequency word; reset value.
REQ-004 Parameter FW_MAX, default 4000, highest legal frequency word.
REQ-005 Parameter WRAP, default 0; 0 = saturate at limits, 1 = wrap to opposite limit.
REQ-006 Parameter N_WAVES, default 4, number of selectable waveforms (2..16).
REQ-007 Parameter DEB_CYCLES, default 1000000, consecutive stable cycles required to accept a button level.
REQ-008 sys_clk  input  1  single clock; all state on rising edge.
REQ-009 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-010 freq_up_n  input  1  asynchronous active-low button; raise frequency.
REQ-011 freq_dn_n  input  1  asynchronous active-low button; lower frequency.
REQ-012 wave_next_n  input  1  asynchronous active-low button; advance waveform.
REQ-013 freq_word  output  FW_WIDTH  registered frequency word for the phase accumulator.
REQ-014 wave_sel  output  4  registered waveform index, 0..N_WAVES-1.
REQ-015 update  output  1  registered one-cycle pulse when freq_word or wave_sel changes.

Function
REQ-016 Each button input SHALL pass through a two-flop synchroniser before any other logic.
REQ-017 Each synchronised button SHALL have an independent debounce counter that clears on any level change and saturates at DEB_CYCLES-1.
REQ-018 A button's debounced level SHALL take the synchronised level in the cycle its counter reaches DEB_CYCLES-1 with input unchanged.
REQ-019 A press event SHALL be a one-cycle pulse on the debounced level's 1->0 transition; release generates no event; holding generates no repeat.
REQ-020 freq_word and wave_sel SHALL update on the clock edge after the press-event cycle; update SHALL assert on that same edge for exactly one cycle.
REQ-021 Up event alone: freq_word + FW_STEP if result <= FW_MAX; otherwise FW_MAX (WRAP=0) or FW_MIN (WRAP=1).
REQ-022 Down event alone: freq_word - FW_STEP if result >= FW_MIN; otherwise FW_MIN (WRAP=0) or FW_MAX (WRAP=1).
REQ-023 Limit comparisons SHALL use FW_WIDTH+1-bit arithmetic so no intermediate overflow or underflow occurs.
REQ-024 Up and down events in the same cycle SHALL leave freq_word unchanged and SHALL NOT assert update unless wave_sel also changes.
REQ-025 Wave event: wave_sel increments by 1, wrapping from N_WAVES-1 to 0.
REQ-026 Wave and frequency events in the same cycle SHALL both take effect with a single update pulse.
REQ-027 update SHALL NOT assert when a saturating step leaves freq_word unchanged (WRAP=0 at a limit).
REQ-028 Parameter legality (FW_MIN <= FW_MAX < 2**FW_WIDTH, FW_STEP >= 1) is the integrator's responsibility; behaviour outside it is undefined.

Reset
REQ-029 On sys_rst_n low: freq_word = FW_MIN, wave_sel = 0, update = 0, synchronisers and debounced levels = 1 (released), debounce counters = 0.
REQ-030 Reset asserted mid-press or mid-debounce SHALL discard the pending event; a button held low through reset release SHALL produce one event after DEB_CYCLES stable cycles.
REQ-031 Outputs SHALL remain at reset values for at least DEB_CYCLES+2 cycles after reset release.

Verification (DEB_CYCLES=4, FW_STEP=8, FW_MIN=8, FW_MAX=32)
REQ-032 Hold freq_up_n low 20 cycles -> freq_word 8->16 once, update high one cycle, no repeat.
REQ-033 Glitch freq_up_n low 2 cycles -> no change, update stays 0.
REQ-034 Four up presses, WRAP=0 -> 16,24,32,32; fourth press gives no update. Same with WRAP=1 -> 16,24,32,8.
REQ-035 Down press at 8 -> 8 with no update (WRAP=0); 32 with update (WRAP=1).
REQ-036 Up and down pressed identically, plus wave_next_n -> freq_word unchanged, wave_sel +1, single update pulse.
REQ-037 Five wave presses, N_WAVES=4 -> wave_sel 1,2,3,0,1; reset mid-debounce -> freq_word=8, wave_sel=0, no event.
